// File: rtl/updown_sweep_pkg.sv
// Shared constants and state encoding for the up/down sweep controller.
package updown_sweep_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SWEEP_W = 4;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StUp   = 3'd2,
    StDown = 3'd3,
    StDone = 3'd4
  } state_e;

  // Index of the final sweep; a request of zero sweeps runs a single sweep.
  function automatic logic [SWEEP_W-1:0] last_sweep(input logic [SWEEP_W-1:0] req);
    return (req == '0) ? '0 : req - 1'b1;
  endfunction

endpackage

// File: rtl/updown_counter4.sv
// 4-bit loadable up/down counter; load has priority over counting.
module updown_counter4
  import updown_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             count_en,
  input  logic             up,
  input  logic [CNT_W-1:0] data_in,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: load, step up/down, or hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = data_in;
    end else if (count_en) begin
      count_d = up ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: runs `sweeps` lo->hi->lo passes of a 4-bit counter.
// Optional macro SWEEP_PAUSE_EN adds a `pause` input that freezes sequencing
// in LOAD/UP/DOWN.
// The counter is loaded with lo as the job is accepted, so it already shows lo
// during LOAD; LOAD then steps to lo+1 and each sweep spends 2*(hi-lo) cycles
// in UP/DOWN.
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
`ifdef SWEEP_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               start,
  input  logic [CNT_W-1:0]   lo,
  input  logic [CNT_W-1:0]   hi,
  input  logic [SWEEP_W-1:0] sweeps,
  output logic [CNT_W-1:0]   count,
  output logic               dir_up,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic [SWEEP_W-1:0] last_q, last_d, sweep_q, sweep_d;
  logic               dir_up_q, busy_q, done_q, err_q, err_d;
  logic               cnt_load, cnt_en, cnt_up;
  logic               hold;

`ifdef SWEEP_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  updown_counter4 u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .count_en (cnt_en),
    .up       (cnt_up),
    .data_in  (lo),
    .count    (count)
  );

  // Next-state and counter-control decode.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    last_d   = last_q;
    sweep_d  = sweep_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_up   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (lo < hi) begin
            lo_d     = lo;
            hi_d     = hi;
            last_d   = last_sweep(sweeps);
            sweep_d  = '0;
            cnt_load = 1'b1;
            state_d  = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (!hold) begin
          cnt_en  = 1'b1;
          cnt_up  = 1'b1;
          state_d = StUp;
        end
      end
      StUp: begin
        if (!hold) begin
          cnt_en = 1'b1;
          if (count == hi_q) begin
            state_d = StDown;
          end else begin
            cnt_up = 1'b1;
          end
        end
      end
      StDown: begin
        if (!hold) begin
          if (count != lo_q) begin
            cnt_en = 1'b1;
          end else begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == last_q) begin
              // Final sweep: count stays parked at lo.
              state_d = StDone;
            end else begin
              cnt_en  = 1'b1;
              cnt_up  = 1'b1;
              state_d = StUp;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, captured job parameters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '0;
      last_q   <= '0;
      sweep_q  <= '0;
      dir_up_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      last_q   <= last_d;
      sweep_q  <= sweep_d;
      dir_up_q <= (state_d == StUp);
      busy_q   <= (state_d inside {StLoad, StUp, StDown});
      done_q   <= (state_d == StDone);
      err_q    <= err_d;
    end
  end

  assign dir_up = dir_up_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl; build with +define+SWEEP_PAUSE_EN
// to include the pause scenario.
`timescale 1ns/1ps
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
`ifdef SWEEP_PAUSE_EN
  logic       pause;
`endif
  logic [3:0] lo, hi, sweeps, count;
  logic       dir_up, busy, done, err;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int jobs_done = 0;
  logic [3:0] model_cnt;

  typedef struct {
    logic [3:0] cnt;
    logic       up;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  updown_sweep_ctrl dut (
    .clk    (clk),
    .reset  (reset),
`ifdef SWEEP_PAUSE_EN
    .pause  (pause),
`endif
    .start  (start),
    .lo     (lo),
    .hi     (hi),
    .sweeps (sweeps),
    .count  (count),
    .dir_up (dir_up),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // Expected busy-cycle sequence: LOAD shows lo, then per sweep lo+1..hi up, hi-1..lo down.
  task automatic push_job(input logic [3:0] l, input logic [3:0] h, input logic [3:0] s);
    int n, li, hv;
    exp_t e;
    li = int'(l);
    hv = int'(h);
    n = (s == 4'd0) ? 1 : int'(s);
    e.cnt = l; e.up = 1'b0;
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      for (int v = li + 1; v <= hv; v++) begin
        e.cnt = 4'(v); e.up = 1'b1;
        exp_q.push_back(e);
      end
      for (int v = hv - 1; v >= li; v--) begin
        e.cnt = 4'(v); e.up = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_done_tail(input string name, input logic [3:0] l);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || count !== l || dir_up !== 1'b0) begin
      failures++;
      $display("FAIL %s done-cycle: busy=%b done=%b count=%0d dir_up=%b, required busy=0 done=1 count=%0d dir_up=0",
               name, busy, done, count, dir_up, l);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== l) begin
      failures++;
      $display("FAIL %s idle-after-done: busy=%b done=%b count=%0d, required busy=0 done=0 count=%0d",
               name, busy, done, count, l);
    end
    jobs_done++;
    model_cnt = l;
  endtask

  task automatic run_job(input string name, input logic [3:0] l, input logic [3:0] h,
                         input logic [3:0] s, input bit disturb);
    exp_t e;
    int idx = 0;
    push_job(l, h, s);
    @(negedge clk);
    lo = l; hi = h; sweeps = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (busy !== 1'b1 || count !== e.cnt || dir_up !== e.up || done !== 1'b0) begin
        failures++;
        $display("FAIL %s step %0d: busy=%b count=%0d dir_up=%b done=%b, required busy=1 count=%0d dir_up=%b done=0",
                 name, idx, busy, count, dir_up, done, e.cnt, e.up);
      end
      // Re-pulse start with a different job while busy; it must be ignored.
      if (disturb && idx == 2) begin
        start = 1'b1; lo = 4'd0; hi = 4'd15; sweeps = 4'd3;
      end
      if (disturb && idx == 4) start = 1'b0;
      idx++;
      @(negedge clk);
    end
    check_done_tail(name, l);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; lo = 4'd0; hi = 4'd0; sweeps = 4'd0;
`ifdef SWEEP_PAUSE_EN
    pause = 1'b0;
`endif
    #12;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset count: got %0d, required 0", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset done: got %b, required 0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset err: got %b, required 0", err); end
    checks++; if (dir_up !== 1'b0) begin failures++; $display("FAIL reset dir_up: got %b, required 0", dir_up); end
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 4'd0;
  endtask

  task automatic test_reject(input string name, input logic [3:0] l, input logic [3:0] h);
    @(negedge clk);
    lo = l; hi = h; sweeps = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || count !== model_cnt) begin
      failures++;
      $display("FAIL %s err-cycle: err=%b busy=%b count=%0d, required err=1 busy=0 count=%0d",
               name, err, busy, count, model_cnt);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || count !== model_cnt) begin
      failures++;
      $display("FAIL %s after-err: err=%b busy=%b count=%0d, required err=0 busy=0 count=%0d",
               name, err, busy, count, model_cnt);
    end
  endtask

  task automatic test_reset_mid_job();
    bit seen_up = 1'b0;
    bit found = 1'b0;
    int d0;
    @(negedge clk);
    lo = 4'd2; hi = 4'd9; sweeps = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (dir_up === 1'b1) seen_up = 1'b1;
      if (seen_up && busy === 1'b1 && dir_up === 1'b0 && count === 4'd7) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_job_reach: count=7 in DOWN not seen within 40 cycles, last count=%0d", count);
    end
    d0 = done_seen;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || dir_up !== 1'b0) begin
      failures++;
      $display("FAIL mid_job_reset: count=%0d busy=%b dir_up=%b, required count=0 busy=0 dir_up=0",
               count, busy, dir_up);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_seen != d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_job_no_done: done pulses=%0d busy=%b, required done pulses=%0d busy=0",
               done_seen, busy, d0);
    end
    model_cnt = 4'd0;
    run_job("post_reset", 4'd1, 4'd3, 4'd1, 1'b0);
  endtask

`ifdef SWEEP_PAUSE_EN
  task automatic test_pause();
    exp_t e;
    int idx = 0;
    bit paused = 1'b0;
    push_job(4'd2, 4'd6, 4'd1);
    @(negedge clk);
    lo = 4'd2; hi = 4'd6; sweeps = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (busy !== 1'b1 || count !== e.cnt || dir_up !== e.up) begin
        failures++;
        $display("FAIL pause step %0d: busy=%b count=%0d dir_up=%b, required busy=1 count=%0d dir_up=%b",
                 idx, busy, count, dir_up, e.cnt, e.up);
      end
      if (!paused && e.up && e.cnt == 4'd4) begin
        paused = 1'b1;
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (busy !== 1'b1 || count !== 4'd4 || dir_up !== 1'b1) begin
            failures++;
            $display("FAIL pause hold %0d: busy=%b count=%0d dir_up=%b, required busy=1 count=4 dir_up=1",
                     k, busy, count, dir_up);
          end
        end
        pause = 1'b0;
      end
      idx++;
      @(negedge clk);
    end
    check_done_tail("pause", 4'd2);
  endtask
`endif

  initial begin
    test_reset();
    run_job("basic_2_5", 4'd2, 4'd5, 4'd1, 1'b0);
    test_reject("reject_equal", 4'd5, 4'd5);
    test_reject("reject_inverted", 4'd9, 4'd3);
    run_job("full_range_x2", 4'd0, 4'd15, 4'd2, 1'b0);
    run_job("sweeps_zero", 4'd3, 4'd4, 4'd0, 1'b0);
    run_job("back_to_back", 4'd6, 4'd10, 4'd1, 1'b1);
    test_reset_mid_job();
`ifdef SWEEP_PAUSE_EN
    test_pause();
`endif
    checks++;
    if (done_seen != jobs_done) begin
      failures++;
      $display("FAIL done_pulse_total: got %0d pulses, required %0d", done_seen, jobs_done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/updown_sweep_ctrl.md
UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge system clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  begin sweep job; sampled only in IDLE.
REQ-004 SHALL have port: lo  input  4  lower sweep bound, unsigned; captured on accepted start.
REQ-005 SHALL have port: hi  input  4  upper sweep bound, unsigned; captured on accepted start.
REQ-006 SHALL have port: sweeps  input  4  number of lo->hi->lo sweeps; 0 treated as 1; captured on accepted start.
REQ-007 SHALL have port: pause  input  1  freeze sequencing; present only when SWEEP_PAUSE_EN is defined.
REQ-008 SHALL have port: count  output  4  current counter value.
REQ-009 SHALL have port: dir_up  output  1  1 in UP state, else 0.
REQ-010 SHALL have port: busy  output  1  1 in LOAD, UP, DOWN.
REQ-011 SHALL have port: done  output  1  one-cycle pulse at job completion.
REQ-012 SHALL have port: err  output  1  one-cycle pulse when start is rejected.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, UP, DOWN, DONE.
REQ-014 IDLE: start=1 with lo<hi SHALL capture lo/hi/sweeps and go to LOAD next cycle.
REQ-015 IDLE: start=1 with lo>=hi SHALL assert err for exactly the next cycle, stay IDLE, count unchanged.
REQ-016 LOAD: SHALL load count<=lo and go to UP; LOAD lasts exactly one cycle.
REQ-017 UP: count!=hi -> count+1; count==hi -> count-1 and go to DOWN.
REQ-018 DOWN: count!=lo -> count-1; count==lo -> sweep counter+1; if sweeps completed go to DONE with count held at lo, else count+1 and go to UP.
REQ-019 DONE: SHALL assert done for exactly one cycle, then IDLE; count holds lo.
REQ-020 One sweep SHALL take 2*(hi-lo) cycles in UP/DOWN; count never leaves [lo,hi]; no 4-bit wrap occurs (lo=0,hi=15 legal).
REQ-021 start while busy or in DONE SHALL be ignored; lo/hi/sweeps changes after capture SHALL have no effect.
REQ-022 IDLE SHALL hold count at its last value.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, count=0, sweep counter=0, dir_up=0, busy=0, done=0, err=0, regardless of clk.
REQ-024 Reset asserted mid-job SHALL abort the job with no done pulse; first start after release is accepted normally.

Configuration
REQ-025 With SWEEP_PAUSE_EN defined, pause=1 in LOAD/UP/DOWN SHALL hold state, count and sweep counter; busy stays 1; pause ignored in IDLE/DONE.
REQ-026 Without SWEEP_PAUSE_EN, pause port SHALL not exist and sequencing never stalls.

Structure
REQ-027 Package updown_sweep_pkg SHALL hold the state encoding, CNT_W=4 and SWEEP_W=4 constants.
REQ-028 Counting SHALL be done by sub-module updown_counter4 (async reset, load, count_en, up, data_in, count); controller drives its controls.

Verification
REQ-029 lo=2,hi=5,sweeps=1, start pulse -> count 2,3,4,5,4,3,2 after LOAD, done pulses once, busy for 7 cycles.
REQ-030 lo=5,hi=5, start -> err one cycle, busy stays 0, count unchanged; lo=9,hi=3 same.
REQ-031 lo=0,hi=15,sweeps=2 -> two full 0..15..0 sweeps, no wrap to 15 from 0, done after 60 UP/DOWN cycles.
REQ-032 reset asserted mid-DOWN at count=7 -> count=0, busy=0 immediately, no done; new start lo=1,hi=3 runs normally.
REQ-033 start re-pulsed with new lo/hi while busy -> ignored, original sequence completes unchanged.
REQ-034 SWEEP_PAUSE_EN: pause=1 for 3 cycles at count=4 in UP -> count holds 4 for 3 cycles then resumes 5; total duration +3 cycles.
